// File: rtl/mirfak_pkg.sv
// Shared definitions for the Wishbone memory arbiter: FSM state encoding,
// owner encoding and the watchdog counter sizing helper.
package mirfak_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic       OWN_I      = 1'b0;
  localparam logic       OWN_D      = 1'b1;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  // Counter width able to hold the value `limit` (at least one bit).
  function automatic int wd_cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_watchdog.sv
// Bus watchdog: counts cycles a strobe stays unanswered and pulses
// timeout_o for one cycle when the count reaches TIMEOUT (0 = disabled).
module wb_watchdog
  import mirfak_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,   // cyc & stb currently presented to the slave
  input  logic resp_i,     // slave ack or err this cycle
  input  logic clear_i,    // arbiter between grants
  output logic timeout_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_wd;
    assign unused_wd = ^{clk_i, rst_ni, active_i, resp_i, clear_i};
    assign timeout_o = 1'b0;
  end else begin : g_on
    localparam int CW = wd_cnt_w(TIMEOUT);
    logic [CW-1:0] cnt_q;

    // Fire only while a strobe is actually outstanding.
    assign timeout_o = active_i && (cnt_q == CW'(TIMEOUT));

    // Count unanswered strobe cycles; any response, a timeout or a return
    // to idle restarts the count.
    always_ff @(posedge clk_i) begin
      if (!rst_ni)
        cnt_q <= '0;
      else if (clear_i || resp_i || timeout_o)
        cnt_q <= '0;
      else if (active_i)
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-to-one Wishbone arbiter (instruction / data master onto one slave).
// Grant is held for the whole cyc; a watchdog errors the owner if the slave
// never answers. Define WB_ARB_ROUND_ROBIN_EN to break simultaneous requests
// by round robin instead of fixed data priority.
module wb_mem_arbiter
  import mirfak_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] iwbs_addr_i,
  input  logic                  iwbs_cyc_i,
  input  logic                  iwbs_stb_i,
  output logic [31:0]           iwbs_dat_o,
  output logic                  iwbs_ack_o,
  output logic                  iwbs_err_o,
  input  logic [ADDR_WIDTH-1:0] dwbs_addr_i,
  input  logic [31:0]           dwbs_dat_i,
  input  logic [3:0]            dwbs_sel_i,
  input  logic                  dwbs_cyc_i,
  input  logic                  dwbs_stb_i,
  input  logic                  dwbs_we_i,
  output logic [31:0]           dwbs_dat_o,
  output logic                  dwbs_ack_o,
  output logic                  dwbs_err_o,
  output logic [ADDR_WIDTH-1:0] wbm_addr_o,
  output logic [31:0]           wbm_dat_o,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  arb_state_e state_q, state_d;
  logic       own_cyc, own_stb, req_active, timeout, bus_resp, wd_clear;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_q;
`endif

  // Owner's cyc/stb; stb without cyc is illegal and never reaches the slave.
  assign own_cyc    = (state_q == GNT_I) ? iwbs_cyc_i :
                      (state_q == GNT_D) ? dwbs_cyc_i : 1'b0;
  assign own_stb    = (state_q == GNT_I) ? iwbs_stb_i :
                      (state_q == GNT_D) ? dwbs_stb_i : 1'b0;
  assign req_active = own_cyc & own_stb;
  assign bus_resp   = wbm_ack_i | wbm_err_i;
  // Every grant change passes through IDLE, so clearing there restarts the
  // count on each new grant.
  assign wd_clear   = (state_q == IDLE);

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .active_i  (req_active),
    .resp_i    (bus_resp),
    .clear_i   (wd_clear),
    .timeout_o (timeout)
  );

  // Arbitration state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Remember who owned the bus last, captured as the grant is released.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      last_q <= OWN_D;
    else if (state_q != IDLE && state_d == IDLE)
      last_q <= (state_q == GNT_I) ? OWN_I : OWN_D;
  end
`endif

  // Next-state decision plus forward and return path muxing.
  always_comb begin
    state_d    = state_q;
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    wbm_sel_o  = '0;
    wbm_we_o   = 1'b0;
    wbm_cyc_o  = own_cyc;
    wbm_stb_o  = req_active & ~timeout;
    iwbs_dat_o = '0;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_dat_o = '0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (iwbs_cyc_i && dwbs_cyc_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          state_d = (last_q == OWN_D) ? GNT_I : GNT_D;
`else
          state_d = GNT_D;
`endif
        end else if (dwbs_cyc_i) begin
          state_d = GNT_D;
        end else if (iwbs_cyc_i) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        wbm_addr_o = iwbs_addr_i;
        wbm_sel_o  = WB_SEL_ALL;
        iwbs_dat_o = wbm_dat_i;
        // A watchdog error pre-empts any ack arriving in the same cycle.
        iwbs_ack_o = wbm_ack_i & ~timeout;
        iwbs_err_o = wbm_err_i | timeout;
        if (!iwbs_cyc_i) state_d = IDLE;
      end
      GNT_D: begin
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_we_o   = dwbs_we_i;
        dwbs_dat_o = wbm_dat_i;
        dwbs_ack_o = wbm_ack_i & ~timeout;
        dwbs_err_o = wbm_err_i | timeout;
        if (!dwbs_cyc_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed + randomized bench for wb_mem_arbiter (TIMEOUT=4).
module tb_wb_mem_arbiter;
  import mirfak_pkg::*;

  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [AW-1:0] iwbs_addr_i, dwbs_addr_i, wbm_addr_o;
  logic          iwbs_cyc_i, iwbs_stb_i, iwbs_ack_o, iwbs_err_o;
  logic [31:0]   iwbs_dat_o, dwbs_dat_i, dwbs_dat_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]    dwbs_sel_i, wbm_sel_o;
  logic          dwbs_cyc_i, dwbs_stb_i, dwbs_we_i, dwbs_ack_o, dwbs_err_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
  logic [6:0]    ctl;

  int total = 0;
  int bad   = 0;

  // Reference-model state: each master's pending request and last owner.
  logic        last_own;
  logic [31:0] ia, da, dd;
  logic [3:0]  ds;
  logic        dw;

  always #5 clk_i = ~clk_i;

  assign ctl = {wbm_cyc_o, wbm_stb_o, wbm_we_o, iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o};

  wb_mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .iwbs_addr_i(iwbs_addr_i), .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i),
    .iwbs_dat_o(iwbs_dat_o), .iwbs_ack_o(iwbs_ack_o), .iwbs_err_o(iwbs_err_o),
    .dwbs_addr_i(dwbs_addr_i), .dwbs_dat_i(dwbs_dat_i), .dwbs_sel_i(dwbs_sel_i),
    .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_we_i(dwbs_we_i),
    .dwbs_dat_o(dwbs_dat_o), .dwbs_ack_o(dwbs_ack_o), .dwbs_err_o(dwbs_err_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // Simultaneous-request winner: data, or the non-last owner with round robin.
  function automatic logic winner();
`ifdef WB_ARB_ROUND_ROBIN_EN
    return (last_own == OWN_D) ? OWN_I : OWN_D;
`else
    return last_own ? OWN_D : OWN_D;
`endif
  endfunction

  task automatic drive(input logic m, input logic on);
    if (m == OWN_I) begin
      iwbs_cyc_i = on; iwbs_stb_i = on; iwbs_addr_i = ia;
    end else begin
      dwbs_cyc_i = on; dwbs_stb_i = on; dwbs_addr_i = da;
      dwbs_dat_i = dd; dwbs_sel_i = ds; dwbs_we_i = dw;
    end
  endtask

  // Called in the first cycle master m owns the bus: the slave answers after
  // `lat` wait cycles, then m releases; checks the dead cycle that follows.
  task automatic serve_one(input logic m, input int lat, input logic [31:0] rd);
    for (int g = 0; g <= lat; g++) begin
      wbm_ack_i = (g == lat);
      wbm_dat_i = rd;
      smp();
      chk("gnt_cyc",  wbm_cyc_o, 1);
      chk("gnt_stb",  wbm_stb_o, 1);
      chk("gnt_addr", wbm_addr_o, (m == OWN_I) ? ia : da);
      chk("gnt_we",   wbm_we_o,   (m == OWN_I) ? 1'b0 : dw);
      chk("gnt_sel",  wbm_sel_o,  (m == OWN_I) ? 4'hF : ds);
      chk("gnt_wdat", wbm_dat_o,  (m == OWN_I) ? 32'h0 : dd);
      if (g == lat) begin
        chk("own_ack",   (m == OWN_I) ? iwbs_ack_o : dwbs_ack_o, 1);
        chk("own_dat",   (m == OWN_I) ? iwbs_dat_o : dwbs_dat_o, rd);
        chk("other_ack", (m == OWN_I) ? dwbs_ack_o : iwbs_ack_o, 0);
        chk("other_dat", (m == OWN_I) ? dwbs_dat_o : iwbs_dat_o, 0);
      end
      nxt();
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    drive(m, 1'b0);
    smp(); chk("drop_cyc", wbm_cyc_o, 0); nxt();
    smp(); chk("dead_cyc", wbm_cyc_o, 0); last_own = m; nxt();
  endtask

  initial begin
    logic w;
    int   req;
    rst_ni = 1'b0;
    iwbs_addr_i = '0; iwbs_cyc_i = 0; iwbs_stb_i = 0;
    dwbs_addr_i = '0; dwbs_dat_i = '0; dwbs_sel_i = '0;
    dwbs_cyc_i = 0; dwbs_stb_i = 0; dwbs_we_i = 0;
    wbm_dat_i = '0; wbm_ack_i = 0; wbm_err_i = 0;
    ia = '0; da = '0; dd = '0; ds = '0; dw = 1'b0;
    last_own = OWN_D;

    // Reset state
    nxt(); nxt();
    smp(); chk("rst_ctl", ctl, 0); chk("rst_addr", wbm_addr_o, 0);
    nxt(); rst_ni = 1'b1;
    smp(); chk("rel_ctl", ctl, 0); nxt();

    // Simultaneous requests straight after reset (last owner = data)
    ia = 32'h0000_1000; da = 32'h0000_2000; dd = 32'h0; ds = 4'hF; dw = 1'b0;
    drive(OWN_I, 1'b1); drive(OWN_D, 1'b1);
    smp(); chk("sim_idle", wbm_cyc_o, 0); nxt();
    w = winner();
    serve_one(w, 0, 32'h1111_0000);
    serve_one(~w, 1, 32'h2222_0000);

    // Instruction-only read, slave acks two cycles after the first strobe
    ia = 32'h8000_0000;
    drive(OWN_I, 1'b1);
    smp(); chk("i_lat0", wbm_cyc_o, 0); nxt();
    smp(); chk("i_lat1", wbm_cyc_o, 1); chk("i_addr", wbm_addr_o, 32'h8000_0000); nxt();
    smp(); chk("i_wait", iwbs_ack_o, 0); nxt();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0013;
    smp(); chk("i_ack", iwbs_ack_o, 1); chk("i_dat", iwbs_dat_o, 32'h13);
    chk("i_dack", dwbs_ack_o, 0); nxt();
    wbm_ack_i = 1'b0; drive(OWN_I, 1'b0);
    smp(); chk("i_drop", wbm_cyc_o, 0); nxt();
    smp(); last_own = OWN_I; nxt();

    // Data write with instruction request blocked behind it
    da = 32'h8000_0100; dd = 32'hDEAD_BEEF; ds = 4'b0011; dw = 1'b1;
    drive(OWN_D, 1'b1);
    smp(); chk("w_idle", wbm_cyc_o, 0); nxt();
    ia = 32'h0000_3000; drive(OWN_I, 1'b1);
    smp(); chk("w_we", wbm_we_o, 1); chk("w_sel", wbm_sel_o, 4'b0011);
    chk("w_dat", wbm_dat_o, 32'hDEAD_BEEF); chk("w_addr", wbm_addr_o, 32'h8000_0100); nxt();
    smp(); chk("w_block", wbm_addr_o, 32'h8000_0100); nxt();
    wbm_ack_i = 1'b1;
    smp(); chk("w_ack", dwbs_ack_o, 1); chk("w_iack", iwbs_ack_o, 0); nxt();
    wbm_ack_i = 1'b0; drive(OWN_D, 1'b0);
    smp(); chk("w_drop", wbm_cyc_o, 0); nxt();
    smp(); chk("w_dead", wbm_cyc_o, 0); last_own = OWN_D; nxt();
    serve_one(OWN_I, 0, 32'h0BAD_F00D);

    // Watchdog: data read never acked
    da = 32'h8000_0200; dw = 1'b0; ds = 4'hF; dd = '0;
    drive(OWN_D, 1'b1);
    smp(); nxt();
    for (int k = 0; k < TO; k++) begin
      smp(); chk("wd_quiet", dwbs_err_o, 0); chk("wd_stb", wbm_stb_o, 1); nxt();
    end
    wbm_ack_i = 1'b1;
    smp(); chk("wd_err", dwbs_err_o, 1); chk("wd_stb0", wbm_stb_o, 0);
    chk("wd_ackdrop", dwbs_ack_o, 0); chk("wd_ierr", iwbs_err_o, 0); nxt();
    wbm_ack_i = 1'b0;
    smp(); chk("wd_after", dwbs_err_o, 0); chk("wd_restb", wbm_stb_o, 1); nxt();
    drive(OWN_D, 1'b0);
    smp(); nxt(); smp(); last_own = OWN_D; nxt();

    // Slave error during an instruction fetch
    ia = 32'h8000_0040;
    drive(OWN_I, 1'b1);
    smp(); nxt();
    wbm_err_i = 1'b1;
    smp(); chk("ie_err", iwbs_err_o, 1); chk("ie_derr", dwbs_err_o, 0); chk("ie_ack", iwbs_ack_o, 0); nxt();
    wbm_err_i = 1'b0; drive(OWN_I, 1'b0);
    smp(); chk("ie_clr", iwbs_err_o, 0); nxt();
    smp(); last_own = OWN_I; nxt();

    // Reset in the middle of a data grant
    da = 32'h8000_0300;
    drive(OWN_D, 1'b1);
    smp(); nxt();
    smp(); chk("rm_gnt", wbm_cyc_o, 1); nxt();
    rst_ni = 1'b0;
    smp(); nxt();
    rst_ni = 1'b1; wbm_ack_i = 1'b1; last_own = OWN_D;
    smp(); chk("rm_ctl", ctl, 0); nxt();
    smp(); chk("rm_regnt", wbm_cyc_o, 1); chk("rm_ack", dwbs_ack_o, 1); nxt();
    wbm_ack_i = 1'b0; drive(OWN_D, 1'b0);
    smp(); nxt(); smp(); last_own = OWN_D; nxt();

    // Illegal: owner drops cyc while keeping stb
    ia = 32'h8000_0080;
    drive(OWN_I, 1'b1);
    smp(); nxt();
    smp(); chk("il_stb1", wbm_stb_o, 1); nxt();
    iwbs_cyc_i = 1'b0;
    smp(); chk("il_mask", wbm_stb_o, 0); chk("il_cyc", wbm_cyc_o, 0); nxt();
    smp(); chk("il_idle", wbm_stb_o, 0); last_own = OWN_I; nxt();
    iwbs_stb_i = 1'b0;
    smp(); nxt();

    // Randomized transactions against the model
    for (int t = 0; t < 30; t++) begin
      req = $urandom_range(1, 3);
      ia = $urandom; da = $urandom; dd = $urandom;
      ds = 4'($urandom_range(0, 15)); dw = 1'($urandom_range(0, 1));
      if (req[0]) drive(OWN_I, 1'b1);
      if (req[1]) drive(OWN_D, 1'b1);
      smp(); chk("rnd_idle", wbm_cyc_o, 0); nxt();
      if (req == 3) begin
        w = winner();
        serve_one(w, $urandom_range(0, 3), $urandom);
        serve_one(~w, $urandom_range(0, 3), $urandom);
      end else begin
        serve_one(req[1] ? OWN_D : OWN_I, $urandom_range(0, 3), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-to-one Wishbone arbiter between the core's instruction master (iwbm) and data master (dwbm).
- Drives a single-port Wishbone slave, so a single-ported RAM or peripheral bus can replace the dual-port testbench memory.
- Grant is locked for the full cycle.
- A bus watchdog returns an error to the current owner when the slave never responds.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- TIMEOUT, 255, cycles a strobe may stay un-acked before a watchdog error is issued; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- iwbs_addr_i  in  ADDR_WIDTH  instruction master address.
- iwbs_cyc_i  in  1  instruction master cycle.
- iwbs_stb_i  in  1  instruction master strobe.
- iwbs_dat_o  out  32  instruction read data.
- iwbs_ack_o  out  1  instruction ack.
- iwbs_err_o  out  1  instruction error.
- dwbs_addr_i  in  ADDR_WIDTH  data master address.
- dwbs_dat_i  in  32  data master write data.
- dwbs_sel_i  in  4  data master byte select.
- dwbs_cyc_i  in  1  data master cycle.
- dwbs_stb_i  in  1  data master strobe.
- dwbs_we_i  in  1  data master write enable.
- dwbs_dat_o  out  32  data read data.
- dwbs_ack_o  out  1  data ack.
- dwbs_err_o  out  1  data error.
- wbm_addr_o  out  ADDR_WIDTH  shared-bus address.
- wbm_dat_o  out  32  shared-bus write data.
- wbm_sel_o  out  4  shared-bus byte select.
- wbm_cyc_o  out  1  shared-bus cycle.
- wbm_stb_o  out  1  shared-bus strobe.
- wbm_we_o  out  1  shared-bus write enable.
- wbm_dat_i  in  32  shared-bus read data.
- wbm_ack_i  in  1  shared-bus ack.
- wbm_err_i  in  1  shared-bus error.

Behaviour:
- Reset (rst_ni=0 at a rising edge):
  - State goes to IDLE, watchdog counter to 0, last-owner flag to DATA.
  - All master-side and slave-side ack, err, cyc, stb and we are 0.
- States:
  - IDLE: no grant; all wbm_* control outputs are 0.
  - GNT_I: instruction master owns the bus.
  - GNT_D: data master owns the bus.
- IDLE transitions (decided from registered-free inputs, taking effect next cycle):
  - Only iwbs_cyc_i high → GNT_I.
  - Only dwbs_cyc_i high → GNT_D.
  - Both high → fixed priority to data (see Optional Feature for the alternative).
  - Arbitration latency is 1 cycle from cyc to the slave seeing cyc.
- GNT_x: the owner's addr, dat, sel, we, cyc and stb are passed combinationally to wbm_*.
  - In GNT_I: wbm_sel_o=4'hF, wbm_we_o=0, wbm_dat_o=0.
- Return path:
  - wbm_ack_i, wbm_err_i and wbm_dat_i are routed only to the owner.
  - The non-owner sees ack=0, err=0, dat=0.
- Lock: the owner keeps the grant while its cyc is high, including multiple strobes.
  - The cycle after the owner drops cyc: state → IDLE, last-owner flag updated.
  - There is no direct GNT_I→GNT_D transition; IDLE always intervenes (one dead cycle).
- Owner cyc low while stb high: illegal. stb is masked to 0 and the state returns to IDLE.
- Watchdog (TIMEOUT>0):
  - Counter increments each cycle with wbm_cyc_o&wbm_stb_o high and neither ack_i nor err_i.
  - Counter clears on ack_i, err_i or a state change.
  - When the counter equals TIMEOUT, for one cycle: owner err_o=1, wbm_stb_o forced to 0, counter cleared.
  - A slave ack arriving in that same cycle is dropped (the error wins).
- A reset mid-transfer drops wbm_cyc_o in the cycle after the reset edge; no ack or err is forwarded.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the master that was not the last owner wins (round robin), using the last-owner flag.
- Undefined: data has fixed priority, and the last-owner flag is unused (synthesised away).

Decomposition:
- Shared package mirfak_pkg holds:
  - state enum: IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2;
  - owner encoding constants: OWN_I=1'b0, OWN_D=1'b1;
  - constant WB_SEL_ALL=4'hF.
- One natural sub-module: wb_watchdog (counter, compare, clear; outputs a timeout pulse), instantiated once.

Test Plan:
- Instruction-only read of 0x8000_0000; slave acks 2 cycles after stb with 0x00000013.
  - wbm_cyc_o rises 1 cycle after iwbs_cyc_i.
  - iwbs_ack_o=1 with iwbs_dat_o=0x00000013; dwbs_ack_o stays 0.
- Simultaneous cyc from both masters in IDLE:
  - fixed priority → GNT_D first, then IDLE, then GNT_I;
  - with WB_ARB_ROUND_ROBIN_EN and last owner=D → GNT_I first.
- Data write 0xDEADBEEF, sel=4'b0011, to 0x8000_0100:
  - wbm_we_o=1, wbm_sel_o=4'b0011, wbm_dat_o=0xDEADBEEF;
  - a concurrently raised instruction cyc is blocked until dwbs_cyc_i drops.
- TIMEOUT=4, slave never acks a data read:
  - dwbs_err_o pulses exactly 4 cycles after the first strobe cycle;
  - wbm_stb_o=0 that cycle.
- rst_ni=0 asserted mid-grant:
  - the next cycle shows wbm_cyc_o=0, all acks and errs 0, state IDLE;
  - a fresh request after rst_ni=1 is granted normally.
- Slave asserts wbm_err_i during an instruction fetch: iwbs_err_o=1 for that cycle and dwbs_err_o=0.
